// File: rtl/frame_stream_arbiter_pkg.sv
// Shared stream-layer constants and types for the frame arbiter.
// Frame geometry defaults and the beat-counter sizing live here so sibling layers agree.
package frame_stream_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    localparam logic SRC_REAL = 1'b0;
    localparam logic SRC_GEN  = 1'b1;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IMG_WIDTH  = 14;
    localparam int DEF_IMG_HEIGHT = 14;

    function automatic int frame_pix(input int width, input int height);
        return width * height;
    endfunction

    // Guard the degenerate single-pixel frame so the counter never collapses to zero bits.
    function automatic int cnt_width(input int pix);
        return (pix > 1) ? $clog2(pix) : 1;
    endfunction

    localparam int DEF_FRAME_PIX = frame_pix(DEF_IMG_WIDTH, DEF_IMG_HEIGHT);
    localparam int DEF_CNT_W     = cnt_width(DEF_FRAME_PIX);

endpackage

// File: rtl/frame_stream_arbiter.sv
// Two-source arbiter that hands the downstream stream to one source per whole frame.
// Round-robin between sources; one registered output stage with hold-on-backpressure.
module frame_stream_arbiter
    import frame_stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in0,
    input  logic signed [DATA_WIDTH-1:0] data_in0,
    output logic                         ready_in0,
    input  logic                         valid_in1,
    input  logic signed [DATA_WIDTH-1:0] data_in1,
    output logic                         ready_in1,
    input  logic                         ready_out,
    output logic                         valid_out,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         src_id,
    output logic                         frame_last,
    output logic                         busy
);

    // state   | meaning
    // IDLE    | no grant held; arbitrate among valid sources
    // XFER    | granted source forwarded until its last frame beat is accepted

    localparam int             FRAME_PIX = frame_pix(IMG_WIDTH, IMG_HEIGHT);
    localparam int             CNT_W     = cnt_width(FRAME_PIX);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_PIX - 1);

    arb_state_t                   r_state;
    arb_state_t                   w_state_nxt;
    logic                         r_grant;
    logic                         w_grant_nxt;
    logic                         r_rr_ptr;
    logic                         w_rr_ptr_nxt;
    logic [CNT_W-1:0]             r_beat;
    logic                         r_valid_out;
    logic signed [DATA_WIDTH-1:0] r_data_out;
    logic                         r_src_id;
    logic                         r_frame_last;

    logic                         w_out_free;
    logic                         w_accept;
    logic                         w_last_beat;
    logic signed [DATA_WIDTH-1:0] w_data_sel;

    assign w_out_free  = !r_valid_out || ready_out;
    assign ready_in0   = (r_state == ST_XFER) && (r_grant == SRC_REAL) && w_out_free;
    assign ready_in1   = (r_state == ST_XFER) && (r_grant == SRC_GEN)  && w_out_free;
    assign w_accept    = (ready_in0 && valid_in0) || (ready_in1 && valid_in1);
    assign w_data_sel  = (r_grant == SRC_GEN) ? data_in1 : data_in0;
    assign w_last_beat = w_accept && (r_beat == LAST_BEAT);

    // r_rr_ptr remembers the last granted source; a contended grant goes to the other one.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (valid_in0 || valid_in1) begin
                    w_state_nxt = ST_XFER;
                    if (valid_in0 && valid_in1) begin
                        w_grant_nxt = ~r_rr_ptr;
                    end else begin
                        w_grant_nxt = valid_in1 ? SRC_GEN : SRC_REAL;
                    end
                    w_rr_ptr_nxt = w_grant_nxt;
                end
            end
            ST_XFER: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= SRC_REAL;
            r_rr_ptr <= SRC_GEN;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    // Output register only moves on an accept or when it drains; otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out  <= 1'b0;
            r_data_out   <= '0;
            r_src_id     <= 1'b0;
            r_frame_last <= 1'b0;
        end else if (w_accept) begin
            r_valid_out  <= 1'b1;
            r_data_out   <= w_data_sel;
            r_src_id     <= r_grant;
            r_frame_last <= w_last_beat;
        end else if (ready_out) begin
            r_valid_out  <= 1'b0;
        end
    end

    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign src_id     = r_src_id;
    assign frame_last = r_frame_last;
    assign busy       = (r_state == ST_XFER);

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Scoreboard bench for frame_stream_arbiter: accepted input beats are queued as expectations
// and popped when the output stage hands them downstream.
module tb_frame_stream_arbiter;

    localparam int DW = 16;
    localparam int FP = 14 * 14;

    typedef struct packed {
        logic          src;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_in0;
    logic signed [DW-1:0] data_in0;
    logic                 ready_in0;
    logic                 valid_in1;
    logic signed [DW-1:0] data_in1;
    logic                 ready_in1;
    logic                 ready_out;
    logic                 valid_out;
    logic signed [DW-1:0] data_out;
    logic                 src_id;
    logic                 frame_last;
    logic                 busy;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    logic frames_done[$];
    int   in_beat;
    int   out_beat;
    logic in_src;

    frame_stream_arbiter #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (14),
        .IMG_HEIGHT (14)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in0  (valid_in0),
        .data_in0   (data_in0),
        .ready_in0  (ready_in0),
        .valid_in1  (valid_in1),
        .data_in1   (data_in1),
        .ready_in1  (ready_in1),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .src_id     (src_id),
        .frame_last (frame_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat0(input int s);
        case (s % 64)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            default: return s[DW-1:0];
        endcase
    endfunction

    // Advances each source's data only after one of its beats was taken.
    task automatic run_generator();
        int   seq0 = 0;
        int   seq1 = 0;
        logic a0;
        logic a1;
        forever begin
            @(negedge clk);
            a0 = valid_in0 && ready_in0;
            a1 = valid_in1 && ready_in1;
            @(posedge clk);
            #2;
            if (!rst_n) begin
                seq0 = 0;
                seq1 = 0;
            end else begin
                if (a0) seq0++;
                if (a1) seq1++;
            end
            data_in0 = pat0(seq0);
            data_in1 = 16'h4000 + seq1[DW-1:0];
        end
    endtask

    task automatic run_monitor();
        exp_t          e;
        logic          s;
        logic          p_stall = 1'b0;
        logic [DW-1:0] p_data = '0;
        logic          p_src = 1'b0;
        logic          p_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                frames_done.delete();
                in_beat  = 0;
                out_beat = 0;
                p_stall  = 1'b0;
            end else begin
                n_checks++;
                if (ready_in0 && ready_in1) begin
                    n_errors++;
                    $display("FAIL ready_excl: ready_in0=%b ready_in1=%b, required at most one high", ready_in0, ready_in1);
                end
                if (p_stall) begin
                    n_checks++;
                    if ({valid_out, data_out, src_id, frame_last} !== {1'b1, p_data, p_src, p_last}) begin
                        n_errors++;
                        $display("FAIL hold: got v=%b d=%h s=%b l=%b, required v=1 d=%h s=%b l=%b",
                                 valid_out, data_out, src_id, frame_last, p_data, p_src, p_last);
                    end
                end
                if (valid_out && ready_out) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL out_unexpected: got d=%h s=%b, required no output", data_out, src_id);
                    end else begin
                        e = sb.pop_front();
                        if ({data_out, src_id, frame_last} !== {e.data, e.src, e.last}) begin
                            n_errors++;
                            $display("FAIL out_data: got d=%h s=%b l=%b, required d=%h s=%b l=%b",
                                     data_out, src_id, frame_last, e.data, e.src, e.last);
                        end
                    end
                    out_beat++;
                    if (frame_last) begin
                        n_checks++;
                        if (out_beat != FP) begin
                            n_errors++;
                            $display("FAIL frame_len: got %0d beats, required %0d", out_beat, FP);
                        end
                        frames_done.push_back(src_id);
                        out_beat = 0;
                    end
                end
                if ((valid_in0 && ready_in0) || (valid_in1 && ready_in1)) begin
                    s = valid_in1 && ready_in1;
                    if (in_beat != 0) begin
                        n_checks++;
                        if (s !== in_src) begin
                            n_errors++;
                            $display("FAIL interleave: got src %b at beat %0d, required src %b", s, in_beat, in_src);
                        end
                    end
                    e.src  = s;
                    e.data = s ? data_in1 : data_in0;
                    e.last = (in_beat == FP - 1);
                    sb.push_back(e);
                    in_src  = s;
                    in_beat = (in_beat == FP - 1) ? 0 : in_beat + 1;
                end
                p_stall = valid_out && !ready_out;
                p_data  = data_out;
                p_src   = src_id;
                p_last  = frame_last;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int cyc = 0;
        while (frames_done.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (frames_done.size() < n) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d frames, required %0d", name, frames_done.size(), n);
        end
    endtask

    task automatic wait_in_beat(input int n, input int budget, input string name);
        int cyc = 0;
        while (in_beat < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (in_beat < n) begin
            n_errors++;
            $display("FAIL %s_timeout: got beat %0d, required %0d", name, in_beat, n);
        end
    endtask

    task automatic check_frame_src(input int idx, input logic exp_src, input string name);
        logic got;
        got = (frames_done.size() > idx) ? frames_done[idx] : 1'bx;
        n_checks++;
        if (got !== exp_src) begin
            n_errors++;
            $display("FAIL %s: frame %0d got src %b, required %b", name, idx, got, exp_src);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        ready_out = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({valid_out, frame_last, busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_flags: got v=%b l=%b busy=%b, required 0 0 0", valid_out, frame_last, busy);
        end
        n_checks++;
        if ({data_out, src_id} !== '0) begin
            n_errors++;
            $display("FAIL rst_data: got d=%h s=%b, required 0", data_out, src_id);
        end
        n_checks++;
        if ({ready_in0, ready_in1} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_ready: got %b%b, required 00", ready_in0, ready_in1);
        end
    endtask

    task automatic test_single_source();
        int cyc = 0;
        do_reset();
        valid_in0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, ready_in0} !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_cycle: got busy=%b ready_in0=%b, required 0 0", busy, ready_in0);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, ready_in0, ready_in1} !== 3'b110) begin
            n_errors++;
            $display("FAIL grant0: got busy=%b r0=%b r1=%b, required 1 1 0", busy, ready_in0, ready_in1);
        end
        while (!(valid_out && frame_last) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({valid_out, frame_last, src_id, busy} !== 4'b1100) begin
            n_errors++;
            $display("FAIL last_beat: got v=%b l=%b s=%b busy=%b, required 1 1 0 0",
                     valid_out, frame_last, src_id, busy);
        end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_gap: got valid_out=%b, required 0", valid_out);
        end
        wait_frames(1, 10, "single");
        check_frame_src(0, 1'b0, "single_src");
    endtask

    task automatic test_data_values();
        logic [DW-1:0] ev[3];
        int cyc = 0;
        ev[0] = 16'h8000;
        ev[1] = 16'h7FFF;
        ev[2] = 16'hFFFF;
        do_reset();
        valid_in0 = 1'b1;
        while (!(valid_in0 && ready_in0) && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({valid_out, data_out} !== {1'b1, ev[k]}) begin
                n_errors++;
                $display("FAIL data_pass%0d: got v=%b d=%h, required v=1 d=%h", k, valid_out, data_out, ev[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        wait_frames(4, 1200, "rr");
        check_frame_src(0, 1'b0, "rr_order");
        check_frame_src(1, 1'b1, "rr_order");
        check_frame_src(2, 1'b0, "rr_order");
        check_frame_src(3, 1'b1, "rr_order");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        int cyc = 0;
        do_reset();
        valid_in0 = 1'b1;
        while (out_beat < 20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 ready_out = 1'b0;
        @(negedge clk);
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({ready_in0, valid_out, data_out, src_id} !== {1'b0, 1'b1, held, 1'b0}) begin
                n_errors++;
                $display("FAIL bp_stall: got r0=%b v=%b d=%h s=%b, required 0 1 %h 0",
                         ready_in0, valid_out, data_out, src_id, held);
            end
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
        wait_frames(1, 400, "bp");
        check_frame_src(0, 1'b0, "bp_src");
    endtask

    task automatic test_source_stall();
        do_reset();
        valid_in1 = 1'b1;
        @(posedge clk);
        #1 valid_in0 = 1'b1;
        wait_in_beat(50, 200, "stall_beat");
        @(posedge clk);
        #1 valid_in1 = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if ({ready_in0, busy} !== 2'b01) begin
                n_errors++;
                $display("FAIL stall_hold: got r0=%b busy=%b, required 0 1", ready_in0, busy);
            end
        end
        @(posedge clk);
        #1 valid_in1 = 1'b1;
        wait_frames(2, 700, "stall");
        check_frame_src(0, 1'b1, "stall_order");
        check_frame_src(1, 1'b0, "stall_order");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        wait_in_beat(100, 300, "mid_beat");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, data_out, src_id, frame_last, busy, ready_in0, ready_in1} !== '0) begin
            n_errors++;
            $display("FAIL mid_rst: got v=%b d=%h s=%b l=%b busy=%b r=%b%b, required all 0",
                     valid_out, data_out, src_id, frame_last, busy, ready_in0, ready_in1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_frames(1, 400, "mid");
        check_frame_src(0, 1'b0, "mid_src");
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        in_beat   = 0;
        out_beat  = 0;
        in_src    = 1'b0;
        rst_n     = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        ready_out = 1'b1;
        data_in0  = 16'h8000;
        data_in1  = 16'h4000;
        fork
            run_generator();
            run_monitor();
        join_none
        test_reset();
        test_single_source();
        test_data_values();
        test_round_robin();
        test_backpressure();
        test_source_stall();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_stream_arbiter.md
FRAME_STREAM_ARBITER -- requirements
Module: frame_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits (signed).
REQ-002 SHALL have parameter IMG_WIDTH, default 14, pixels per line of one unpadded frame.
REQ-003 SHALL have parameter IMG_HEIGHT, default 14, lines per unpadded frame; FRAME_PIX = IMG_WIDTH*IMG_HEIGHT.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-005 valid_in0  input  1  source 0 (real-image stream) has a sample.
REQ-006 data_in0  input  DATA_WIDTH signed  source 0 sample.
REQ-007 ready_in0  output  1  source 0 sample accepted this cycle when valid_in0 is also high.
REQ-008 valid_in1 / data_in1 / ready_in1: same as REQ-005..007 for source 1 (generator stream).
REQ-009 ready_out  input  1  downstream (zero-pad layer) accepts data_out.
REQ-010 valid_out  output  1  data_out holds a sample.
REQ-011 data_out  output  DATA_WIDTH signed  forwarded sample.
REQ-012 src_id  output  1  source of the sample on data_out, valid with valid_out.
REQ-013 frame_last  output  1  data_out is the last (FRAME_PIX-th) sample of its frame.
REQ-014 busy  output  1  high while a frame grant is held (state XFER).

Function
REQ-015 SHALL share the single downstream stream between two sources at whole-frame granularity; a grant never switches mid-frame.
REQ-016 States: IDLE (no grant), XFER (granted source forwarded); IDLE->XFER when any valid_inN high; XFER->IDLE on acceptance of the FRAME_PIX-th sample.
REQ-017 In IDLE with one valid source: grant that source on the next edge; no sample accepted in the IDLE cycle.
REQ-018 In IDLE with both valid: grant the source not granted last (round-robin pointer); after reset the pointer favours source 0.
REQ-019 Round-robin pointer SHALL update at grant time to the granted source.
REQ-020 ready_inN = (state==XFER) && (grant==N) && (!valid_out || ready_out); non-granted ready_in always 0.
REQ-021 Accepted sample SHALL appear on data_out/src_id with valid_out one cycle later (latency 1).
REQ-022 When valid_out && !ready_out: data_out, src_id, frame_last, valid_out SHALL hold unchanged.
REQ-023 When the output register empties and no sample is accepted, valid_out SHALL drop to 0 next cycle.
REQ-024 Beat counter width SHALL be clog2(FRAME_PIX), counting accepted samples 0..FRAME_PIX-1, cleared on frame end; no wrap beyond FRAME_PIX-1.
REQ-025 frame_last SHALL be registered with the sample accepted at count FRAME_PIX-1.
REQ-026 Minimum one IDLE cycle between frames; back-to-back frames SHALL alternate when both sources remain valid.
REQ-027 Data SHALL pass unmodified (no arithmetic, no sign change).
REQ-028 A source dropping valid_in mid-frame SHALL stall the grant (no timeout, no re-arbitration).

Reset
REQ-029 On rst_n low: state=IDLE, valid_out=0, data_out=0, src_id=0, frame_last=0, busy=0, beat counter=0, pointer favours source 0, ready_in0=ready_in1=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first post-reset frame starts at count 0.

Structure
REQ-031 State encodings and FRAME_PIX/count-width localparams SHALL live in the shared layer package alongside other stream-layer constants.
REQ-032 No sub-module; single module with one registered output stage.

Verification
REQ-033 Only source 0 valid, ready_out=1, IMG 14x14 -> 196 samples out with src_id=0, frame_last on 196th, busy drops, valid_out gap >=1 cycle.
REQ-034 Both valid continuously after reset -> frames ordered src 0,1,0,1; each exactly 196 beats; no interleaving within a frame.
REQ-035 ready_out held low 5 cycles mid-frame -> data_out/src_id stable, ready_in of granted source 0, no sample lost or duplicated.
REQ-036 Source 1 granted, valid_in1 low 10 cycles at beat 50 while valid_in0 high -> grant held, source 0 ready_in0 stays 0, frame resumes at beat 51.
REQ-037 rst_n asserted at beat 100 -> outputs zero immediately; next frame emits full 196 beats starting from source 0 if both valid.
REQ-038 Data 0x8000, 0x7FFF, -1 -> identical values at data_out, one cycle latency.
